spi_dac_frame_rx: RTL and testbench

SPI responder that accepts MCP4911-format 16-bit write frames from an external controller (Arduino header) and presents them as a 10-bit control value inside the synth. It is the receiving end of the frame our MCP4911 drivers transmit. It lets an external MCU inject CV (e.g. VCO frequency or VCA volume) in place of an MCP3001 reading. It optionally holds each update until the next 44.1 kHz `sample_clk` pulse, emulating the DAC's LDAC behaviour.

---
 rtl/spi_dac_frame_rx.sv | 146 ++++++++++++++
 tb/tb_spi_dac_frame_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_frame_rx.sv
// SPI responder for MCP4911-format 16-bit write frames. Pins are synchronized
// into clk, a small FSM collects one frame per CS-low window, and accepted
// frames are committed to the control outputs either immediately on CS rise or
// on the next sample_clk strobe (LDAC-style), depending on LATCH_ON_SAMPLE.
module spi_dac_frame_rx #(
    parameter int LATCH_ON_SAMPLE = 1,
    parameter int MIN_HALF        = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sample_clk,
    input  logic       SCK_PIN,
    input  logic       CS_PIN,
    input  logic       MOSI_PIN,
    output logic [9:0] data_out,
    output logic       buf_out,
    output logic       gain_1x,
    output logic       shdn_n,
    output logic       frame_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam bit LATCH = (LATCH_ON_SAMPLE != 0);
    // Reset value of the committed fields {BUF, GA_n, SHDN_n, D9..D0}.
    localparam logic [12:0] OUT_RST = {1'b0, 1'b1, 1'b1, 10'd0};

    // Below two clk per level, consecutive SCK edges can merge inside the
    // synchronizer and bits are lost; nothing in this block can compensate.
    if (MIN_HALF < 2) begin : g_min_half_unsupported
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_sck_sync;   // [1] synchronized, [2] previous for edge detect
    logic [2:0]  r_cs_sync;
    logic [1:0]  r_mosi_sync;
    logic [4:0]  r_cnt;
    logic [15:0] r_sr;
    logic [12:0] r_stage;
    logic        r_pending;
    logic [12:0] r_out;

    logic w_sck_rise;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_accept;
    logic w_bad_len;
    logic w_commit_direct;
    logic w_commit_stage;

    // Synchronizers; reset to 0 so a CS already low at reset release does not
    // look like a falling edge and a frame in flight is never picked up.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sck_sync  <= 3'b000;
            r_cs_sync   <= 3'b000;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], SCK_PIN};
            r_cs_sync   <= {r_cs_sync[1:0], CS_PIN};
            r_mosi_sync <= {r_mosi_sync[0], MOSI_PIN};
        end
    end

    assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and length/A-B resolution of the collected frame.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_bad_len   = 1'b0;
        case (r_state)
            IDLE:  if (w_cs_fall) w_state_nxt = SHIFT;
            SHIFT: if (w_cs_rise) w_state_nxt = CHECK;
            CHECK: begin
                w_state_nxt = IDLE;
                if (r_cnt == 5'd16) w_accept  = ~r_sr[15];
                else                w_bad_len = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bit counter and shift register; counter saturates at 17 so any overlong
    // frame still reads as a bad length.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= 5'd0;
            r_sr  <= 16'd0;
        end else if (r_state == IDLE && w_cs_fall) begin
            r_cnt <= 5'd0;
            r_sr  <= 16'd0;
        end else if (r_state == SHIFT && w_sck_rise) begin
            r_sr <= {r_sr[14:0], r_mosi_sync[1]};
            if (r_cnt != 5'd17) r_cnt <= r_cnt + 5'd1;
        end
    end

    // A frame accepted in the same cycle as a strobe bypasses staging, so the
    // newest frame always wins.
    assign w_commit_direct = w_accept & (~LATCH | sample_clk);
    assign w_commit_stage  = LATCH & sample_clk & r_pending & ~w_accept;

    // Staging, pending flag and committed outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stage   <= 13'd0;
            r_pending <= 1'b0;
            r_out     <= OUT_RST;
        end else begin
            if (w_commit_direct)     r_out <= r_sr[14:2];
            else if (w_commit_stage) r_out <= r_stage;

            if (LATCH && w_accept && !sample_clk) begin
                r_stage   <= r_sr[14:2];
                r_pending <= 1'b1;
            end else if (sample_clk) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign buf_out     = r_out[12];
    assign gain_1x     = r_out[11];
    assign shdn_n      = r_out[10];
    assign data_out    = r_out[9:0];
    assign frame_valid = reset_n & (w_commit_direct | w_commit_stage);
    assign frame_error = reset_n & w_bad_len;
    assign busy        = reset_n & (r_state == SHIFT);

endmodule

// File: tb/tb_spi_dac_frame_rx.sv
// Bench for spi_dac_frame_rx: one instance per commit mode on shared pins,
// directed scenarios plus randomized frames against a frame-level model.
module tb_spi_dac_frame_rx;

    logic clk = 1'b0, reset_n = 1'b0, sample_clk = 1'b0;
    logic sck = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic [9:0] data0, data1;
    logic buf0, buf1, ga0, ga1, sd0, sd1, fv0, fv1, fe0, fe1, busy0, busy1;
    logic [12:0] o0, o1;
    assign o0 = {buf0, ga0, sd0, data0};
    assign o1 = {buf1, ga1, sd1, data1};

    int checks = 0, errors = 0, cyc = 0;
    int n_fv0 = 0, n_fv1 = 0, n_fe0 = 0, n_fe1 = 0, n_overlap = 0, n_fv1_nosamp = 0;
    int fv0_cyc = 0, busy0_rise = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
    logic busy0_q = 1'b0;

    // Frame-level model
    logic [12:0] m_out0, m_out1, m_stage1;
    bit m_pend1;
    int exp_fv0 = 0, exp_fv1 = 0, exp_fe0 = 0, exp_fe1 = 0;

    spi_dac_frame_rx #(.LATCH_ON_SAMPLE(0), .MIN_HALF(3)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .sample_clk(sample_clk), .SCK_PIN(sck),
        .CS_PIN(cs), .MOSI_PIN(mosi), .data_out(data0), .buf_out(buf0),
        .gain_1x(ga0), .shdn_n(sd0), .frame_valid(fv0), .frame_error(fe0), .busy(busy0));

    spi_dac_frame_rx #(.LATCH_ON_SAMPLE(1), .MIN_HALF(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sample_clk(sample_clk), .SCK_PIN(sck),
        .CS_PIN(cs), .MOSI_PIN(mosi), .data_out(data1), .buf_out(buf1),
        .gain_1x(ga1), .shdn_n(sd1), .frame_valid(fv1), .frame_error(fe1), .busy(busy1));

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pulse monitor, sampled mid-cycle after the negedge-driven inputs settle.
    always @(negedge clk) begin
        #1;
        if (fv0) begin n_fv0++; fv0_cyc = cyc; end
        if (fv1) n_fv1++;
        if (fe0) n_fe0++;
        if (fe1) n_fe1++;
        if ((fv0 && fe0) || (fv1 && fe1)) n_overlap++;
        if (fv1 && !sample_clk) n_fv1_nosamp++;
        if (busy0 && !busy0_q) busy0_rise = cyc;
        busy0_q = busy0;
    end

    // Field mapping {BUF, GA_n, SHDN_n, D9..D0} from a 16-bit frame.
    function automatic logic [12:0] fields(input logic [15:0] f);
        return {f[14], f[13], f[12], f[11:2]};
    endfunction

    task automatic model_reset();
        m_out0 = {1'b0, 1'b1, 1'b1, 10'd0};
        m_out1 = {1'b0, 1'b1, 1'b1, 10'd0};
        m_stage1 = 13'd0;
        m_pend1 = 1'b0;
    endtask

    task automatic model_sample();
        if (m_pend1) begin m_out1 = m_stage1; m_pend1 = 1'b0; exp_fv1++; end
    endtask

    task automatic model_frame(input logic [31:0] w, input int n, input bit same);
        bit acc;
        acc = (n == 16) && !w[15];
        if (n != 16) begin exp_fe0++; exp_fe1++; end
        if (acc) begin m_out0 = fields(w[15:0]); exp_fv0++; end
        if (acc && same) begin m_out1 = fields(w[15:0]); m_pend1 = 1'b0; exp_fv1++; end
        else if (acc) begin m_stage1 = fields(w[15:0]); m_pend1 = 1'b1; end
        else if (same) model_sample();
    endtask

    // Pin drivers (all called at a negedge)
    task automatic spi_bits(input logic [31:0] w, input int hi, input int lo, input int h);
        for (int i = hi; i >= lo; i--) begin
            mosi = w[i];
            repeat (h) @(negedge clk);
            sck = 1'b1;
            repeat (h) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic spi_send(input logic [31:0] w, input int n, input int h, input int samp_at);
        cs = 1'b0; cs_fall_cyc = cyc;
        repeat (h) @(negedge clk);
        spi_bits(w, n - 1, 0, h);
        repeat (h) @(negedge clk);
        cs = 1'b1; cs_rise_cyc = cyc;
        for (int j = 1; j <= h + 6; j++) begin
            @(negedge clk);
            sample_clk = (j == samp_at);
        end
        sample_clk = 1'b0;
    endtask

    task automatic pulse_sample();
        sample_clk = 1'b1;
        @(negedge clk);
        sample_clk = 1'b0;
        repeat (2) @(negedge clk);
        model_sample();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (o0 !== 13'h0C00) begin errors++; $display("FAIL reset_out0: got %h want %h", o0, 13'h0C00); end
        checks++; if (o1 !== 13'h0C00) begin errors++; $display("FAIL reset_out1: got %h want %h", o1, 13'h0C00); end
        checks++; if ({busy0, busy1} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", {busy0, busy1}); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            sck = 1'($urandom_range(0, 1));
            sample_clk = (i % 300 == 150);
        end
        sck = 1'b0; sample_clk = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (n_fv0 + n_fv1 + n_fe0 + n_fe1 !== 0) begin errors++; $display("FAIL idle_pulses: got %0d want 0", n_fv0 + n_fv1 + n_fe0 + n_fe1); end
        checks++; if ({o0, o1} !== {m_out0, m_out1}) begin errors++; $display("FAIL idle_outs: got %h/%h want %h/%h", o0, o1, m_out0, m_out1); end
    endtask

    task automatic test_direct();
        spi_send(32'h3FFC, 16, 5, 0);
        model_frame(32'h3FFC, 16, 0);
        checks++; if (o0 !== 13'h0FFF) begin errors++; $display("FAIL direct_out0: got %h want %h", o0, 13'h0FFF); end
        checks++; if (n_fv0 !== exp_fv0) begin errors++; $display("FAIL direct_fv0_count: got %0d want %0d", n_fv0, exp_fv0); end
        checks++; if (fv0_cyc - cs_rise_cyc !== 3) begin errors++; $display("FAIL direct_fv_latency: got %0d want 3", fv0_cyc - cs_rise_cyc); end
        checks++; if (busy0_rise - cs_fall_cyc !== 3) begin errors++; $display("FAIL busy_latency: got %0d want 3", busy0_rise - cs_fall_cyc); end
        checks++; if (o1 !== m_out1 || n_fv1 !== 0) begin errors++; $display("FAIL latch_held: got %h fv %0d want %h fv 0", o1, n_fv1, m_out1); end
        pulse_sample();
        checks++; if (o1 !== 13'h0FFF || n_fv1 !== exp_fv1) begin errors++; $display("FAIL latch_commit: got %h fv %0d want %h fv %0d", o1, n_fv1, 13'h0FFF, exp_fv1); end
    endtask

    task automatic test_latch();
        int base;
        spi_send(32'h3804, 16, 4, 0); model_frame(32'h3804, 16, 0);
        spi_send(32'h3808, 16, 4, 0); model_frame(32'h3808, 16, 0);
        base = n_fv1;
        pulse_sample();
        // 0x3808 has bits 11 and 3 set -> D9 and D1 -> 0x202
        checks++; if (n_fv1 - base !== 1) begin errors++; $display("FAIL newest_wins_pulses: got %0d want 1", n_fv1 - base); end
        checks++; if (data1 !== 10'h202) begin errors++; $display("FAIL newest_wins_data: got %h want %h", data1, 10'h202); end
        pulse_sample();
        checks++; if (n_fv1 - base !== 1) begin errors++; $display("FAIL pending_cleared: got %0d want 1", n_fv1 - base); end
    endtask

    task automatic test_bad_length();
        int e0, e1;
        spi_send(32'h3010, 16, 3, 0); model_frame(32'h3010, 16, 0);
        e0 = n_fe0; e1 = n_fe1;
        spi_send(32'h1FFE, 15, 3, 0); model_frame(32'h1FFE, 15, 0);
        spi_send(32'h07FF8, 17, 3, 0); model_frame(32'h07FF8, 17, 0);
        spi_send(32'h0, 0, 3, 0); model_frame(32'h0, 0, 0);
        checks++; if (n_fe0 - e0 !== 3 || n_fe1 - e1 !== 3) begin errors++; $display("FAIL bad_len_errors: got %0d/%0d want 3/3", n_fe0 - e0, n_fe1 - e1); end
        spi_send(32'hB7FC, 16, 3, 0); model_frame(32'hB7FC, 16, 0);
        checks++; if (n_fe0 - e0 !== 3 || n_fv0 !== exp_fv0) begin errors++; $display("FAIL ab_ignored: fe %0d fv %0d want 3 %0d", n_fe0 - e0, n_fv0, exp_fv0); end
        checks++; if (o0 !== fields(16'h3010)) begin errors++; $display("FAIL bad_len_hold0: got %h want %h", o0, fields(16'h3010)); end
        pulse_sample();
        checks++; if (o1 !== fields(16'h3010)) begin errors++; $display("FAIL bad_len_stage_kept: got %h want %h", o1, fields(16'h3010)); end
    endtask

    task automatic test_shutdown();
        spi_send(32'h2550, 16, 4, 0); model_frame(32'h2550, 16, 0);
        pulse_sample();
        checks++; if ({sd0, ga0, buf0, data0} !== {1'b0, 1'b1, 1'b0, 10'h154}) begin errors++; $display("FAIL shdn_fields0: got %b%b%b %h want 010 154", sd0, ga0, buf0, data0); end
        checks++; if ({sd1, ga1, buf1, data1} !== {1'b0, 1'b1, 1'b0, 10'h154}) begin errors++; $display("FAIL shdn_fields1: got %b%b%b %h want 010 154", sd1, ga1, buf1, data1); end
        checks++; if (n_fv0 !== exp_fv0 || n_fv1 !== exp_fv1) begin errors++; $display("FAIL shdn_pulses: got %0d/%0d want %0d/%0d", n_fv0, n_fv1, exp_fv0, exp_fv1); end
    endtask

    task automatic test_same_cycle();
        int base;
        spi_send(32'h3010, 16, 4, 0); model_frame(32'h3010, 16, 0);
        base = n_fv1;
        spi_send(32'h3020, 16, 4, 3); model_frame(32'h3020, 16, 1);
        checks++; if (n_fv1 - base !== 1 || data1 !== 10'h008) begin errors++; $display("FAIL same_cycle: got fv %0d data %h want 1 008", n_fv1 - base, data1); end
        pulse_sample();
        checks++; if (n_fv1 - base !== 1) begin errors++; $display("FAIL same_cycle_no_pending: got %0d want 1", n_fv1 - base); end
    endtask

    task automatic test_reset_midframe();
        int tot;
        tot = n_fv0 + n_fv1 + n_fe0 + n_fe1;
        cs = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(32'h3FFC, 15, 8, 4);
        reset_n = 1'b0; model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        spi_bits(32'h3FFC, 7, 0, 4);
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (n_fv0 + n_fv1 + n_fe0 + n_fe1 !== tot) begin errors++; $display("FAIL midframe_pulses: got %0d want %0d", n_fv0 + n_fv1 + n_fe0 + n_fe1, tot); end
        checks++; if ({o0, o1} !== {m_out0, m_out1}) begin errors++; $display("FAIL midframe_outs: got %h/%h want %h/%h", o0, o1, m_out0, m_out1); end
        spi_send(32'h3004, 16, 4, 0); model_frame(32'h3004, 16, 0);
        pulse_sample();
        checks++; if (data0 !== 10'h001 || data1 !== 10'h001) begin errors++; $display("FAIL rearm_data: got %h/%h want 001/001", data0, data1); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        int n, h, sel;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 4);
            n = (sel == 0) ? 15 : (sel == 4) ? 17 : 16;
            w = $urandom;
            if (n == 16 && $urandom_range(0, 3) != 0) w[15] = 1'b0;
            h = $urandom_range(3, 6);
            spi_send(w, n, h, 0);
            model_frame(w, n, 0);
            if ($urandom_range(0, 1) == 1) pulse_sample();
            checks++; if ({o0, o1} !== {m_out0, m_out1}) begin errors++; $display("FAIL rand_outs it%0d: got %h/%h want %h/%h", it, o0, o1, m_out0, m_out1); end
            checks++; if ({n_fv0, n_fv1, n_fe0, n_fe1} !== {exp_fv0, exp_fv1, exp_fe0, exp_fe1}) begin
                errors++;
                $display("FAIL rand_counts it%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", it, n_fv0, n_fv1, n_fe0, n_fe1, exp_fv0, exp_fv1, exp_fe0, exp_fe1);
            end
        end
    endtask

    task automatic test_invariants();
        checks++; if (n_overlap !== 0) begin errors++; $display("FAIL valid_error_overlap: got %0d want 0", n_overlap); end
        checks++; if (n_fv1_nosamp !== 0) begin errors++; $display("FAIL latch_valid_off_strobe: got %0d want 0", n_fv1_nosamp); end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_idle();
        test_direct();
        test_latch();
        test_bad_length();
        test_shutdown();
        test_same_cycle();
        test_reset_midframe();
        test_random();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
